// File: rtl/lfsr_rng.sv
// Fibonacci-LFSR random-word generator with seed load, zero-lockup guard,
// optional rejection sampling against a caller bound, and a
// request/valid/ready word interface.
module lfsr_rng #(
  parameter int                 WIDTH = 32,
  parameter logic [WIDTH-1:0]   TAPS  = 32'h8020_0003,
  parameter logic [WIDTH-1:0]   SEED  = 32'h0000_0001,
  parameter int                 OUT_W = 16,
  parameter int                 STEPS = 16
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               seed_load,
  input  logic [WIDTH-1:0]   seed,
  input  logic               req,
  input  logic [OUT_W-1:0]   bound,
  output logic [OUT_W-1:0]   rnd,
  output logic               rnd_valid,
  input  logic               rnd_ready,
  output logic               busy,
  output logic [WIDTH-1:0]   lfsr_q
);

  // A zero seed would lock the LFSR forever, so it is replaced by 1.
  localparam logic [WIDTH-1:0] SEED_EFF =
    (SEED == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : SEED;

  localparam int               CNT_W = $clog2(STEPS + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   lfsr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]   bound_q, bound_d;
  logic [OUT_W-1:0]   rnd_q, rnd_d;

  logic               fb;
  logic [WIDTH-1:0]   shift_next;
  logic [OUT_W-1:0]   cand;

  // One LFSR step; an all-zero state restarts from the seed instead.
  always_comb begin
    fb         = ^(lfsr_q & TAPS);
    shift_next = (lfsr_q == '0) ? SEED_EFF : {lfsr_q[WIDTH-2:0], fb};
    cand       = shift_next[OUT_W-1:0];
  end

  // Next-state logic: seed load overrides the FSM; RUN shifts and tests
  // the candidate on the last step of each word.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    bound_d = bound_q;
    rnd_d   = rnd_q;
    if (seed_load) begin
      lfsr_d  = (seed == '0) ? SEED_EFF : seed;
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req) begin
            state_d = RUN;
            cnt_d   = '0;
            bound_d = bound;
          end
        end
        RUN: begin
          lfsr_d = shift_next;
          if (cnt_q == LAST) begin
            cnt_d = '0;
            if ((bound_q == '0) || (cand < bound_q)) begin
              rnd_d   = cand;
              state_d = HOLD;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        HOLD: begin
          if (rnd_ready) begin
            if (req) begin
              state_d = RUN;
              cnt_d   = '0;
              bound_d = bound;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      lfsr_q  <= SEED_EFF;
      cnt_q   <= '0;
      bound_q <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      bound_q <= bound_d;
      rnd_q   <= rnd_d;
    end
  end

  assign rnd       = rnd_q;
  assign rnd_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_lfsr_rng.sv
// Directed, table-driven bench for lfsr_rng in a 4-bit configuration
// (TAPS=9, SEED=1, OUT_W=4, STEPS=4) with hand-computed expectations.
module tb_lfsr_rng;

  logic       clk;
  logic       clr_n;
  logic       seed_load;
  logic [3:0] seed;
  logic       req;
  logic [3:0] bound;
  logic [3:0] rnd;
  logic       rnd_valid;
  logic       rnd_ready;
  logic       busy;
  logic [3:0] lfsr_q;

  int vecCount  = 0;
  int missCount = 0;

  lfsr_rng #(
    .WIDTH(4), .TAPS(4'h9), .SEED(4'h1), .OUT_W(4), .STEPS(4)
  ) dut (
    .clk(clk), .clr_n(clr_n), .seed_load(seed_load), .seed(seed),
    .req(req), .bound(bound), .rnd(rnd), .rnd_valid(rnd_valid),
    .rnd_ready(rnd_ready), .busy(busy), .lfsr_q(lfsr_q)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       sl;
    logic [3:0] sd;
    logic       rq;
    logic [3:0] bd;
    logic       rdy;
    logic [3:0] expRnd;
    logic       expValid;
    logic       expBusy;
    logic [3:0] expLfsr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic sl, logic [3:0] sd, logic rq, logic [3:0] bd,
                              logic rdy, logic [3:0] r, logic v, logic b, logic [3:0] l);
    vec_t t;
    t.sl = sl; t.sd = sd; t.rq = rq; t.bd = bd; t.rdy = rdy;
    t.expRnd = r; t.expValid = v; t.expBusy = b; t.expLfsr = l;
    return t;
  endfunction

  // Drive inputs just after an edge, then wait for the next edge plus 1 ns.
  task automatic applyStimulus(input logic sl, input logic [3:0] sd, input logic rq,
                               input logic [3:0] bd, input logic rdy);
    seed_load = sl; seed = sd; req = rq; bound = bd; rnd_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic chkRnd, input logic [3:0] r,
                             input logic v, input logic b, input logic [3:0] l);
    vecCount++;
    if ((chkRnd && rnd !== r) || rnd_valid !== v || busy !== b || lfsr_q !== l) begin
      missCount++;
      $display("[TB] FAIL %s: got rnd=%h valid=%b busy=%b lfsr=%h, want rnd=%h valid=%b busy=%b lfsr=%h",
               name, rnd, rnd_valid, busy, lfsr_q, r, v, b, l);
    end
  endtask

  task automatic doReset();
    seed_load = 0; seed = 0; req = 0; bound = 0; rnd_ready = 1;
    clr_n = 0;
    @(posedge clk);
    #3;
    checkOutput("reset", 1'b1, 4'h0, 1'b0, 1'b0, 4'h1);
    clr_n = 1;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] seq[15] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5,
                          4'hB, 4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8};

  initial begin
    int idx;
    int changes;
    logic [3:0] prev;

    clr_n = 0; seed_load = 0; seed = 0; req = 0; bound = 0; rnd_ready = 1;

    // T1: free-running requests walk the full 15-state sequence twice.
    doReset();
    idx = 0;
    checkOutput("t1_start", 1'b0, 4'h0, 1'b0, 1'b0, seq[0]);
    changes = 0;
    prev = lfsr_q;
    for (int c = 0; c < 200 && changes < 30; c++) begin
      applyStimulus(1'b0, 4'h0, 1'b1, 4'h0, 1'b1);
      if (lfsr_q !== prev) begin
        idx = (idx + 1) % 15;
        changes++;
        vecCount++;
        if (lfsr_q !== seq[idx] || lfsr_q === 4'h0) begin
          missCount++;
          $display("[TB] FAIL t1_step%0d: got lfsr=%h, want %h", changes, lfsr_q, seq[idx]);
        end
        prev = lfsr_q;
      end
    end
    vecCount++;
    if (changes != 30) begin
      missCount++;
      $display("[TB] FAIL t1_budget: got %0d shifts, want 30", changes);
    end

    // T2 / T3 via vector table, starting from a fresh reset.
    doReset();
    vecs.push_back(mk(0, 4'h0, 1, 4'h0, 1, 4'h0, 0, 1, 4'h1));
    vecs.push_back(mk(0, 4'h0, 0, 4'h0, 1, 4'h0, 0, 1, 4'h3));
    vecs.push_back(mk(0, 4'h0, 0, 4'h0, 1, 4'h0, 0, 1, 4'h7));
    vecs.push_back(mk(0, 4'h0, 0, 4'h0, 1, 4'h0, 0, 1, 4'hF));
    vecs.push_back(mk(0, 4'h0, 0, 4'h0, 1, 4'hE, 1, 1, 4'hE));
    vecs.push_back(mk(0, 4'h0, 0, 4'h0, 1, 4'hE, 0, 0, 4'hE));
    vecs.push_back(mk(1, 4'h1, 0, 4'h0, 1, 4'hE, 0, 0, 4'h1));
    vecs.push_back(mk(0, 4'h0, 1, 4'h5, 1, 4'hE, 0, 1, 4'h1));
    vecs.push_back(mk(0, 4'h0, 0, 4'h0, 1, 4'hE, 0, 1, 4'h3));
    vecs.push_back(mk(0, 4'h0, 0, 4'h0, 1, 4'hE, 0, 1, 4'h7));
    vecs.push_back(mk(0, 4'h0, 0, 4'h0, 1, 4'hE, 0, 1, 4'hF));
    vecs.push_back(mk(0, 4'h0, 0, 4'h0, 1, 4'hE, 0, 1, 4'hE));
    vecs.push_back(mk(0, 4'h0, 0, 4'h0, 1, 4'hE, 0, 1, 4'hD));
    vecs.push_back(mk(0, 4'h0, 0, 4'h0, 1, 4'hE, 0, 1, 4'hA));
    vecs.push_back(mk(0, 4'h0, 0, 4'h0, 1, 4'hE, 0, 1, 4'h5));
    vecs.push_back(mk(0, 4'h0, 0, 4'h0, 1, 4'hE, 0, 1, 4'hB));
    vecs.push_back(mk(0, 4'h0, 0, 4'h0, 1, 4'hE, 0, 1, 4'h6));
    vecs.push_back(mk(0, 4'h0, 0, 4'h0, 1, 4'hE, 0, 1, 4'hC));
    vecs.push_back(mk(0, 4'h0, 0, 4'h0, 1, 4'hE, 0, 1, 4'h9));
    vecs.push_back(mk(0, 4'h0, 0, 4'h0, 0, 4'h2, 1, 1, 4'h2));
    vecs.push_back(mk(0, 4'h0, 0, 4'h0, 0, 4'h2, 1, 1, 4'h2));
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].sl, vecs[i].sd, vecs[i].rq, vecs[i].bd, vecs[i].rdy);
      checkOutput($sformatf("vec%0d", i), 1'b1, vecs[i].expRnd, vecs[i].expValid,
                  vecs[i].expBusy, vecs[i].expLfsr);
    end

    // T4: consumer stalls for 10 cycles, then accepts with a back-to-back request.
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b0, 4'h0, 1'b1, 4'h0, 1'b0);
      checkOutput($sformatf("t4_stall%0d", c), 1'b1, 4'h2, 1'b1, 1'b1, 4'h2);
    end
    applyStimulus(1'b0, 4'h0, 1'b1, 4'h0, 1'b1);
    checkOutput("t4_accept", 1'b1, 4'h2, 1'b0, 1'b1, 4'h2);
    applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
    checkOutput("t4_run", 1'b1, 4'h2, 1'b0, 1'b1, 4'h1);
    applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
    checkOutput("t4_next", 1'b1, 4'h3, 1'b1, 1'b1, 4'h3);

    // T5: seed load mid-RUN, zero seed falls back to SEED, then a real seed.
    applyStimulus(1'b0, 4'h0, 1'b1, 4'h0, 1'b1);
    applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    checkOutput("t5_run", 1'b0, 4'h0, 1'b0, 1'b1, 4'h7);
    applyStimulus(1'b1, 4'h0, 1'b1, 4'h0, 1'b1);
    checkOutput("t5_seed0", 1'b0, 4'h0, 1'b0, 1'b0, 4'h1);
    applyStimulus(1'b1, 4'h6, 1'b0, 4'h0, 1'b1);
    checkOutput("t5_seed6", 1'b0, 4'h0, 1'b0, 1'b0, 4'h6);

    // T6: asynchronous clear between edges mid-RUN, then replay T2.
    applyStimulus(1'b0, 4'h0, 1'b1, 4'h0, 1'b1);
    applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    checkOutput("t6_run", 1'b0, 4'h0, 1'b0, 1'b1, 4'hC);
    #2;
    clr_n = 0;
    #1;
    checkOutput("t6_clear", 1'b1, 4'h0, 1'b0, 1'b0, 4'h1);
    #2;
    clr_n = 1;
    applyStimulus(1'b0, 4'h0, 1'b1, 4'h0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
      checkOutput($sformatf("t6_busy%0d", c), 1'b1, 4'h0, 1'b0, 1'b1, seq[c + 1]);
    end
    applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    checkOutput("t6_word", 1'b1, 4'hE, 1'b1, 1'b1, 4'hE);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
